// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch/controller definitions: default widths, halt word and FSM encoding.
package instr_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_W    = 16;
  localparam int unsigned IFU_DATA_W    = 16;
  localparam logic [15:0] IFU_HALT_WORD = 16'hFFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  function automatic logic is_busy_state(input logic [1:0] st);
    return (st == ST_ISSUE) || (st == ST_WAIT);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_counter.sv
// Program counter register with parallel load and modulo-2^ADDR_W increment.
module pc_counter #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Load wins over increment; the adder wraps naturally at all-ones.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_val_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/ISSUE/WAIT fetch FSM with pending jump,
// sticky halt and WAIT timeout; the PC lives in pc_counter.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W    = IFU_ADDR_W,
  parameter int unsigned       DATA_W    = IFU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}},
  parameter int unsigned       TIMEOUT   = 15,
  parameter logic [DATA_W-1:0] HALT_WORD = IFU_HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_rvalid,
  output logic [DATA_W-1:0] IR,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fetch_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_t_q, pend_t_d;
  logic [DATA_W-1:0] ir_q;
  logic              ir_valid_q, halted_q, fetch_err_q, imem_rd_q, busy_q;

  logic              pc_load_s;
  logic [ADDR_W-1:0] pc_load_val_s;
  logic              pc_inc_s;
  logic              accept_s;
  logic              abort_s;
  logic [ADDR_W-1:0] pc_s;

  // Next-state, pending-jump and PC control decode.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_v_d      = pend_v_q;
    pend_t_d      = pend_t_q;
    pc_load_s     = 1'b0;
    pc_load_val_s = jump_target;
    pc_inc_s      = 1'b0;
    accept_s      = 1'b0;
    abort_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d     = {CNT_W{1'b0}};
        pc_load_s = jump_en;
        if (fetch_req && !halted_q) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (jump_en) begin
          pend_v_d = 1'b1;
          pend_t_d = jump_target;
        end else begin
          pend_v_d = pend_v_q;
        end
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (jump_en) begin
          pend_v_d = 1'b1;
          pend_t_d = jump_target;
        end else begin
          pend_v_d = pend_v_q;
        end
        if (imem_rvalid) begin
          accept_s = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = {CNT_W{1'b0}};
          pend_v_d = 1'b0;
          // A jump (pending or arriving now) overrides both increment and halt-hold.
          if (jump_en) begin
            pc_load_s     = 1'b1;
            pc_load_val_s = jump_target;
          end else if (pend_v_q) begin
            pc_load_s     = 1'b1;
            pc_load_val_s = pend_t_q;
          end else if (imem_rdata == HALT_WORD) begin
            pc_inc_s = 1'b0;
          end else begin
            pc_inc_s = 1'b1;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          abort_s  = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = {CNT_W{1'b0}};
          pend_v_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = {CNT_W{1'b0}};
        pend_v_d = 1'b0;
      end
    endcase
  end

  // FSM, pending jump, IR and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      pend_v_q    <= 1'b0;
      pend_t_q    <= {ADDR_W{1'b0}};
      ir_q        <= {DATA_W{1'b0}};
      ir_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
      imem_rd_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_v_q    <= pend_v_d;
      pend_t_q    <= pend_t_d;
      ir_q        <= accept_s ? imem_rdata : ir_q;
      ir_valid_q  <= accept_s;
      halted_q    <= halted_q | (accept_s && (imem_rdata == HALT_WORD));
      fetch_err_q <= abort_s;
      imem_rd_q   <= (state_d == ST_ISSUE);
      busy_q      <= is_busy_state(state_d);
    end
  end

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .reset      (reset),
    .load_i     (pc_load_s),
    .load_val_i (pc_load_val_s),
    .inc_i      (pc_inc_s),
    .pc_o       (pc_s)
  );

  assign pc        = pc_s;
  assign imem_addr = pc_s;
  assign IR        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = halted_q;
  assign fetch_err = fetch_err_q;
  assign imem_rd   = imem_rd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit against a transaction-level fetch model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        fetch_req;
  logic        jump_en;
  logic [15:0] jump_target;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_rdata;
  logic        imem_rvalid;
  logic [15:0] ir;
  logic        ir_valid;
  logic [15:0] pc;
  logic        busy;
  logic        halted;
  logic        fetch_err;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;

  // Reference model: architectural state after each completed transaction.
  logic [15:0] m_pc;
  logic [15:0] m_ir;
  logic        m_halted;

  instr_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_req   (fetch_req),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_rdata  (imem_rdata),
    .imem_rvalid (imem_rvalid),
    .IR          (ir),
    .ir_valid    (ir_valid),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (imem_rd === 1'b1) rd_cnt++;

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_req = 1'b0; jump_en = 1'b0; jump_target = 16'h0;
    imem_rdata = 16'h0; imem_rvalid = 1'b0;
    next_cycle(); next_cycle();
    reset = 1'b0;
    m_pc = 16'h0; m_ir = 16'h0; m_halted = 1'b0;
    @(negedge clk);
    n_tests++; if (pc !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", pc); end
    n_tests++; if (imem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    n_tests++; if (ir !== 16'h0) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", ir); end
    n_tests++;
    if ({ir_valid, imem_rd, busy, halted, fetch_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {ir_valid, imem_rd, busy, halted, fetch_err});
    end
  endtask

  // One fetch with memory latency lat; jmode 0 none, 1 jump with request,
  // 2 jump in ISSUE, 3 jump in ISSUE overwritten in first WAIT cycle.
  task automatic do_fetch(input int lat, input logic [15:0] data, input int jmode,
                          input logic [15:0] t1, input logic [15:0] t2,
                          input bit extra_req, input string name);
    logic [15:0] addr;
    int rd0;
    addr = (jmode == 1) ? t1 : m_pc;
    rd0 = rd_cnt;
    fetch_req = 1'b1;
    if (jmode == 1) begin jump_en = 1'b1; jump_target = t1; end
    next_cycle();
    fetch_req = 1'b0; jump_en = 1'b0;
    if (jmode >= 2) begin jump_en = 1'b1; jump_target = t1; end
    if (extra_req) fetch_req = 1'b1;
    @(negedge clk);
    n_tests++; if (imem_rd !== 1'b1) begin n_fail++; $display("FAIL %s issue_rd: got %b want 1", name, imem_rd); end
    n_tests++; if (imem_addr !== addr) begin n_fail++; $display("FAIL %s issue_addr: got %h want %h", name, imem_addr, addr); end
    for (int w = 1; w <= lat; w++) begin
      next_cycle();
      jump_en = 1'b0; fetch_req = 1'b0;
      imem_rvalid = (w == lat);
      imem_rdata  = (w == lat) ? data : 16'($urandom);
      if (jmode == 3 && w == 1 && lat >= 2) begin jump_en = 1'b1; jump_target = t2; end
      if (extra_req && w == 1) fetch_req = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({busy, imem_rd, ir_valid} !== 3'b100) begin
        n_fail++; $display("FAIL %s wait%0d busy/rd/irv: got %b want 100", name, w, {busy, imem_rd, ir_valid});
      end
    end
    next_cycle();
    imem_rvalid = 1'b0; jump_en = 1'b0; fetch_req = 1'b0;
    m_ir = data;
    if (data == 16'hFFFF) m_halted = 1'b1;
    if (jmode == 3 && lat >= 2) m_pc = t2;
    else if (jmode >= 2) m_pc = t1;
    else if (data == 16'hFFFF) m_pc = addr;
    else m_pc = addr + 16'd1;
    @(negedge clk);
    n_tests++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL %s ir_valid: got %b want 1", name, ir_valid); end
    n_tests++; if (ir !== m_ir) begin n_fail++; $display("FAIL %s ir: got %h want %h", name, ir, m_ir); end
    n_tests++; if (pc !== m_pc) begin n_fail++; $display("FAIL %s pc: got %h want %h", name, pc, m_pc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_done: got %b want 0", name, busy); end
    n_tests++; if (halted !== m_halted) begin n_fail++; $display("FAIL %s halted: got %b want %b", name, halted, m_halted); end
    next_cycle();
    @(negedge clk);
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL %s ir_valid_pulse: got %b want 0", name, ir_valid); end
    next_cycle();
    n_tests++; if (rd_cnt - rd0 !== 1) begin n_fail++; $display("FAIL %s rd_count: got %0d want 1", name, rd_cnt - rd0); end
  endtask

  task automatic test_jump_idle(input logic [15:0] tgt);
    int rd0;
    rd0 = rd_cnt;
    jump_en = 1'b1; jump_target = tgt;
    next_cycle();
    jump_en = 1'b0;
    m_pc = tgt;
    @(negedge clk);
    n_tests++; if (pc !== m_pc) begin n_fail++; $display("FAIL jump_idle pc: got %h want %h", pc, m_pc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL jump_idle busy: got %b want 0", busy); end
    next_cycle();
    n_tests++; if (rd_cnt != rd0) begin n_fail++; $display("FAIL jump_idle rd: got %0d reads want 0", rd_cnt - rd0); end
  endtask

  task automatic test_basic();
    do_fetch(1, 16'h1234, 0, 16'h0, 16'h0, 1'b0, "basic");
    do_fetch(4, 16'hBEEF, 0, 16'h0, 16'h0, 1'b1, "dropped_req");
    do_fetch(15, 16'h0F0F, 0, 16'h0, 16'h0, 1'b0, "last_wait_cycle");
  endtask

  task automatic test_wrap();
    test_jump_idle(16'hFFFF);
    do_fetch(2, 16'h5555, 0, 16'h0, 16'h0, 1'b0, "wrap");
  endtask

  task automatic test_jumps();
    do_fetch(3, 16'hA5A5, 2, 16'h0040, 16'h0, 1'b0, "jump_wait");
    do_fetch(2, 16'h0001, 1, 16'h1200, 16'h0, 1'b0, "jump_with_req");
    do_fetch(3, 16'h0002, 3, 16'h0300, 16'h0777, 1'b0, "jump_overwrite");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [15:0] d;
      d = 16'($urandom);
      if (d == 16'hFFFF) d = 16'h0;
      if ($urandom_range(0, 4) == 0) test_jump_idle(16'($urandom));
      do_fetch($urandom_range(1, 6), d, $urandom_range(0, 3), 16'($urandom), 16'($urandom),
               1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_timeout();
    logic [15:0] old_pc, old_ir;
    old_pc = m_pc; old_ir = m_ir;
    fetch_req = 1'b1;
    next_cycle();
    fetch_req = 1'b0; jump_en = 1'b1; jump_target = 16'h0BAD;
    @(negedge clk);
    n_tests++; if (imem_rd !== 1'b1) begin n_fail++; $display("FAIL timeout issue_rd: got %b want 1", imem_rd); end
    for (int w = 1; w <= 15; w++) begin
      next_cycle();
      jump_en = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({busy, fetch_err} !== 2'b10) begin
        n_fail++; $display("FAIL timeout wait%0d busy/err: got %b want 10", w, {busy, fetch_err});
      end
    end
    next_cycle();
    @(negedge clk);
    n_tests++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL timeout err: got %b want 1", fetch_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout busy: got %b want 0", busy); end
    n_tests++; if (pc !== old_pc) begin n_fail++; $display("FAIL timeout pc: got %h want %h", pc, old_pc); end
    n_tests++; if (ir !== old_ir) begin n_fail++; $display("FAIL timeout ir: got %h want %h", ir, old_ir); end
    next_cycle();
    imem_rvalid = 1'b1; imem_rdata = 16'h7777;
    @(negedge clk);
    n_tests++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL timeout err_pulse: got %b want 0", fetch_err); end
    next_cycle();
    imem_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL late_rvalid irv: got %b want 0", ir_valid); end
    n_tests++; if (ir !== old_ir) begin n_fail++; $display("FAIL late_rvalid ir: got %h want %h", ir, old_ir); end
    do_fetch(2, 16'h3333, 0, 16'h0, 16'h0, 1'b0, "after_timeout");
  endtask

  task automatic test_halt();
    do_fetch(2, 16'hFFFF, 0, 16'h0, 16'h0, 1'b0, "halt");
    fetch_req = 1'b1;
    next_cycle();
    fetch_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if ({imem_rd, busy, halted} !== 3'b001) begin
        n_fail++; $display("FAIL halted_req c%0d rd/busy/halt: got %b want 001", c, {imem_rd, busy, halted});
      end
      next_cycle();
    end
    test_reset();
    do_fetch(3, 16'hFFFF, 2, 16'h0123, 16'h0, 1'b0, "halt_with_jump");
    test_reset();
  endtask

  task automatic test_reset_mid();
    test_jump_idle(16'h4321);
    fetch_req = 1'b1;
    next_cycle();
    fetch_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h9999;
    m_pc = 16'h0; m_ir = 16'h0; m_halted = 1'b0;
    @(negedge clk);
    n_tests++; if (pc !== 16'h0) begin n_fail++; $display("FAIL reset_mid pc: got %h want 0000", pc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy: got %b want 0", busy); end
    next_cycle();
    imem_rvalid = 1'b0;
    @(negedge clk);
    n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid irv: got %b want 0", ir_valid); end
    n_tests++; if (ir !== 16'h0) begin n_fail++; $display("FAIL reset_mid ir: got %h want 0000", ir); end
    next_cycle();
    do_fetch(1, 16'h4444, 0, 16'h0, 16'h0, 1'b0, "after_reset_mid");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_jumps();
    test_random();
    test_timeout();
    test_halt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
  ADDR_W, 16, program-counter and instruction-memory address width.
  DATA_W, 16, instruction word width; must equal the controller IR width.
  RESET_PC, 0, PC value after reset.
  TIMEOUT, 15, maximum wait cycles for imem_rvalid before abort.
  HALT_WORD, 16'hFFFF, instruction word that halts fetching.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
  clk, in, 1, single clock; all state updates on the rising edge.
  reset, in, 1, synchronous, active-high reset.
  fetch_req, in, 1, one-cycle request from the controller to fetch the next instruction.
  jump_en, in, 1, load PC from jump_target; condition is already resolved by the controller.
  jump_target, in, ADDR_W, jump destination.
  imem_addr, out, ADDR_W, instruction-memory read address.
  imem_rd, out, 1, instruction-memory read strobe, one cycle per fetch.
  imem_rdata, in, DATA_W, instruction-memory read data.
  imem_rvalid, in, 1, imem_rdata valid this cycle.
  IR, out, DATA_W, latched instruction; feeds the controller IR input.
  ir_valid, out, 1, one-cycle pulse when IR is updated.
  pc, out, ADDR_W, current program counter.
  busy, out, 1, high while a fetch is outstanding.
  halted, out, 1, sticky flag set when HALT_WORD is fetched.
  fetch_err, out, 1, one-cycle pulse on a fetch timeout.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, ISSUE, WAIT.
REQ-004 In IDLE with fetch_req=1 and halted=0, the FSM SHALL go to ISSUE.
REQ-005 In IDLE, fetch_req SHALL be ignored while halted=1.
REQ-006 In ISSUE, the unit SHALL drive imem_rd=1 and imem_addr=pc for exactly one cycle, then go to WAIT.
REQ-007 imem_rd SHALL be 0 in every state other than ISSUE.
REQ-008 In WAIT with imem_rvalid=1, the unit SHALL, in the same edge:
  latch IR<=imem_rdata;
  pulse ir_valid=1 on the following cycle;
  update pc;
  return to IDLE.
  Fetch latency from fetch_req to ir_valid is therefore 2 cycles plus the memory latency.
REQ-009 On a normal fetch, pc SHALL advance by 1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-010 If imem_rdata==HALT_WORD, then:
  IR SHALL still be latched and ir_valid pulsed;
  halted SHALL be set;
  pc SHALL not advance.
REQ-011 jump_en in IDLE SHALL load pc<=jump_target on the next edge, with no memory access.
REQ-012 If jump_en and fetch_req are both high in IDLE, then:
  pc SHALL load jump_target;
  the fetch SHALL issue from jump_target;
  after completion pc SHALL equal jump_target+1.
REQ-013 jump_en in ISSUE or WAIT SHALL be held in a one-entry pending register; on completion pc SHALL load the pending target instead of incrementing.
REQ-014 A later jump_en SHALL overwrite the pending target.
REQ-015 A pending jump SHALL have priority over the HALT_WORD rule for pc; halted SHALL still be set.
REQ-016 fetch_req in ISSUE or WAIT SHALL be dropped without queuing.
REQ-017 busy SHALL be 1 exactly in ISSUE and WAIT.
REQ-018 A WAIT-cycle counter SHALL abort after TIMEOUT cycles without imem_rvalid; on abort:
  return to IDLE;
  pulse fetch_err;
  leave IR and pc unchanged;
  clear any pending jump.
REQ-019 imem_rvalid outside WAIT SHALL be ignored.

Reset
REQ-020 On reset=1 at a clock edge, the unit SHALL set:
  state=IDLE;
  pc=RESET_PC;
  IR=0;
  ir_valid=0, imem_rd=0, busy=0, halted=0, fetch_err=0;
  imem_addr=RESET_PC;
  pending jump cleared;
  timeout counter=0.
REQ-021 Reset asserted mid-fetch SHALL abandon the fetch; a late imem_rvalid after reset SHALL be ignored.
REQ-022 reset SHALL take priority over all other inputs.

Structure
REQ-023 The FSM state encoding, HALT_WORD and the default widths SHALL live in the shared controller package.
REQ-024 The PC register with load/increment SHALL be a sub-module pc_counter; everything else SHALL be inline.

Verification
REQ-025 Reset then fetch_req with memory latency 1 and imem_rdata=16'h1234 -> imem_rd at cycle 1 with addr 0; ir_valid at cycle 3; IR=16'h1234; pc=1.
REQ-026 pc=16'hFFFF, fetch completes -> pc=0.
REQ-027 jump_en with target 16'h0040 during WAIT, then rvalid -> IR from the old address; pc=16'h0040; no extra imem_rd.
REQ-028 imem_rdata=16'hFFFF -> halted=1; pc unchanged; subsequent fetch_req produces no imem_rd until reset.
REQ-029 No imem_rvalid for 15 WAIT cycles -> fetch_err pulse; busy=0; pc and IR unchanged; a late rvalid is ignored.
REQ-030 Reset asserted during WAIT -> next cycle pc=0, busy=0; a subsequent rvalid produces no ir_valid.
